axi_rd_arbiter: RTL

- Shares one AXI read manager port among N_MST requesters.
- Arbitrates the AR channel and widens each granted ID with the requester index.
- Routes R beats back by that index and caps outstanding bursts per requester.
- Sits between multiple UVM AXI read masters (or DUT-side initiators) and a single AXI subordinate agent on the verification fabric.

---
 rtl/axi_rd_arbiter_if.sv | 72 +++++++
 rtl/axi_rd_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter_if
//
// Signal bundle for the N_MST-to-1 AXI read arbiter. Carries the flattened
// requester-side AR/R channels (s_*) and the single manager-side port (m_*).
//
// Modports:
//   slave  : arbiter view (takes requester AR and manager R, drives the rest)
//   master : environment view (requesters + subordinate), opposite directions
//
// Parameters: N_MST, ID_WIDTH, ADDR_WIDTH, DATA_WIDTH. The manager-side ID is
// widened by IDX_W = max(1, clog2(N_MST)) bits carrying the requester index.
// ---------------------------------------------------------------------------
interface axi_rd_arbiter_if #(
    parameter int unsigned N_MST      = 2,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
);
    localparam int unsigned IDX_W = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int unsigned MID_W = IDX_W + ID_WIDTH;

    // Requester side, flattened per requester
    logic [N_MST-1:0]            s_ar_valid;
    logic [N_MST-1:0]            s_ar_ready;
    logic [N_MST*ID_WIDTH-1:0]   s_ar_id;
    logic [N_MST*ADDR_WIDTH-1:0] s_ar_addr;
    logic [N_MST*8-1:0]          s_ar_len;
    logic [N_MST*3-1:0]          s_ar_size;
    logic [N_MST*2-1:0]          s_ar_burst;
    logic [N_MST*4-1:0]          s_ar_qos;
    logic [N_MST-1:0]            s_r_valid;
    logic [N_MST-1:0]            s_r_ready;
    // Shared R payload
    logic [ID_WIDTH-1:0]         s_r_id;
    logic [DATA_WIDTH-1:0]       s_r_data;
    logic [1:0]                  s_r_resp;
    logic                        s_r_last;
    // Manager side
    logic                        m_ar_valid;
    logic                        m_ar_ready;
    logic [MID_W-1:0]            m_ar_id;
    logic [ADDR_WIDTH-1:0]       m_ar_addr;
    logic [7:0]                  m_ar_len;
    logic [2:0]                  m_ar_size;
    logic [1:0]                  m_ar_burst;
    logic [3:0]                  m_ar_qos;
    logic                        m_r_valid;
    logic                        m_r_ready;
    logic [MID_W-1:0]            m_r_id;
    logic [DATA_WIDTH-1:0]       m_r_data;
    logic [1:0]                  m_r_resp;
    logic                        m_r_last;

    modport slave (
        input  s_ar_valid, s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_qos,
        input  s_r_ready,
        output s_ar_ready, s_r_valid, s_r_id, s_r_data, s_r_resp, s_r_last,
        output m_ar_valid, m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_qos,
        output m_r_ready,
        input  m_ar_ready, m_r_valid, m_r_id, m_r_data, m_r_resp, m_r_last
    );

    modport master (
        output s_ar_valid, s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_qos,
        output s_r_ready,
        input  s_ar_ready, s_r_valid, s_r_id, s_r_data, s_r_resp, s_r_last,
        input  m_ar_valid, m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_qos,
        input  m_r_ready,
        output m_ar_ready, m_r_valid, m_r_id, m_r_data, m_r_resp, m_r_last
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//
// Shares one AXI read manager port among N_MST requesters. The AR channel is
// arbitrated (round-robin) and the granted ID is widened with the requester
// index; R beats are routed back combinationally by that index. Each
// requester may hold at most MAX_OUTSTANDING open bursts.
//
// Ports:
//   clk       : clock, all state on posedge
//   rst_n     : asynchronous active-low reset
//   bus       : axi_rd_arbiter_if.slave, requester s_* and manager m_* channels
//   route_err : pulses while an R beat is dropped (unroutable index) or a
//               last beat arrives for a requester with no open burst
//
// Build option: define AXI_RD_ARB_QOS_EN to pick the highest-qos eligible
// requester (round-robin among equal qos). Without it selection is pure
// round-robin; qos is still forwarded on m_ar_qos.
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int unsigned N_MST           = 2,
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    axi_rd_arbiter_if.slave    bus,
    output logic               route_err
);
    localparam int unsigned IDX_W = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int unsigned MID_W = IDX_W + ID_WIDTH;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [CNT_W-1:0]        cnt_q [N_MST];
    logic [CNT_W-1:0]        cnt_d [N_MST];
    logic [MID_W-1:0]        ar_id_q, ar_id_d;
    logic [ADDR_WIDTH-1:0]   ar_addr_q, ar_addr_d;
    logic [7:0]              ar_len_q, ar_len_d;
    logic [2:0]              ar_size_q, ar_size_d;
    logic [1:0]              ar_burst_q, ar_burst_d;
    logic [3:0]              ar_qos_q, ar_qos_d;

    logic [N_MST-1:0]        eligible;
    logic                    any_elig;
    logic [IDX_W-1:0]        winner;
    logic [N_MST-1:0]        ar_ready;

    logic [IDX_W-1:0]        r_idx;
    logic                    r_routable;
    logic [N_MST-1:0]        r_valid;
    logic                    r_sel_ready;
    logic                    r_ready;
    logic                    r_last_hs;
    logic                    underflow;

    // -----------------------------------------------------------------------
    // Eligibility and winner selection
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < int'(N_MST); i++) begin
            eligible[i] = bus.s_ar_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    // Walk candidates in round-robin order starting after last_grant. With
    // QoS, a later candidate only displaces the current pick on strictly
    // higher qos, so ties fall to round-robin order.
    always_comb begin
        int unsigned cand;
`ifdef AXI_RD_ARB_QOS_EN
        logic [3:0] best_qos;
        best_qos = '0;
`endif
        any_elig = 1'b0;
        winner   = '0;
        cand     = 0;
        for (int unsigned k = 1; k <= N_MST; k++) begin
            cand = (32'(last_grant_q) + k) % N_MST;
`ifdef AXI_RD_ARB_QOS_EN
            if (eligible[cand] && (!any_elig || (bus.s_ar_qos[cand*4 +: 4] > best_qos))) begin
                any_elig = 1'b1;
                winner   = IDX_W'(cand);
                best_qos = bus.s_ar_qos[cand*4 +: 4];
            end
`else
            if (eligible[cand] && !any_elig) begin
                any_elig = 1'b1;
                winner   = IDX_W'(cand);
            end
`endif
        end
    end

    // -----------------------------------------------------------------------
    // AR state machine
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ar_id_d      = ar_id_q;
        ar_addr_d    = ar_addr_q;
        ar_len_d     = ar_len_q;
        ar_size_d    = ar_size_q;
        ar_burst_d   = ar_burst_q;
        ar_qos_d     = ar_qos_q;
        ar_ready     = '0;
        unique case (state_q)
            StIdle: begin
                if (any_elig) begin
                    ar_ready     = N_MST'(1) << winner;
                    ar_id_d      = {winner, bus.s_ar_id[winner*ID_WIDTH +: ID_WIDTH]};
                    ar_addr_d    = bus.s_ar_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                    ar_len_d     = bus.s_ar_len[winner*8 +: 8];
                    ar_size_d    = bus.s_ar_size[winner*3 +: 3];
                    ar_burst_d   = bus.s_ar_burst[winner*2 +: 2];
                    ar_qos_d     = bus.s_ar_qos[winner*4 +: 4];
                    last_grant_d = winner;
                    state_d      = StHold;
                end
            end
            StHold: begin
                if (bus.m_ar_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // -----------------------------------------------------------------------
    // R routing (combinational)
    // -----------------------------------------------------------------------
    assign r_idx      = bus.m_r_id[MID_W-1 -: IDX_W];
    assign r_routable = (32'(r_idx) < N_MST);

    always_comb begin
        r_valid     = '0;
        r_sel_ready = 1'b0;
        for (int i = 0; i < int'(N_MST); i++) begin
            if (r_idx == IDX_W'(i)) begin
                r_valid[i]  = bus.m_r_valid;
                r_sel_ready = bus.s_r_ready[i];
            end
        end
    end

    // Unroutable beats are swallowed so the subordinate never stalls.
    assign r_ready   = rst_n && (r_routable ? r_sel_ready : 1'b1);
    assign r_last_hs = bus.m_r_valid && r_ready && bus.m_r_last && r_routable;

    // -----------------------------------------------------------------------
    // Outstanding-burst counters
    // -----------------------------------------------------------------------
    always_comb begin
        underflow = 1'b0;
        for (int i = 0; i < int'(N_MST); i++) begin
            logic inc, dec_req, dec_ok;
            inc     = ar_ready[i] && bus.s_ar_valid[i];
            dec_req = r_last_hs && (r_idx == IDX_W'(i));
            dec_ok  = dec_req && (cnt_q[i] != '0);
            cnt_d[i] = cnt_q[i];
            if (dec_req && (cnt_q[i] == '0)) begin
                underflow = 1'b1;
            end
            if (inc && !dec_ok) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!inc && dec_ok) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= IDX_W'(N_MST - 1);
            ar_id_q      <= '0;
            ar_addr_q    <= '0;
            ar_len_q     <= '0;
            ar_size_q    <= '0;
            ar_burst_q   <= '0;
            ar_qos_q     <= '0;
            for (int i = 0; i < int'(N_MST); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ar_id_q      <= ar_id_d;
            ar_addr_q    <= ar_addr_d;
            ar_len_q     <= ar_len_d;
            ar_size_q    <= ar_size_d;
            ar_burst_q   <= ar_burst_d;
            ar_qos_q     <= ar_qos_d;
            for (int i = 0; i < int'(N_MST); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.s_ar_ready = rst_n ? ar_ready : '0;
    assign bus.m_ar_valid = (state_q == StHold);
    assign bus.m_ar_id    = ar_id_q;
    assign bus.m_ar_addr  = ar_addr_q;
    assign bus.m_ar_len   = ar_len_q;
    assign bus.m_ar_size  = ar_size_q;
    assign bus.m_ar_burst = ar_burst_q;
    assign bus.m_ar_qos   = ar_qos_q;

    assign bus.s_r_valid  = r_valid;
    assign bus.m_r_ready  = r_ready;
    assign bus.s_r_id     = bus.m_r_id[ID_WIDTH-1:0];
    assign bus.s_r_data   = bus.m_r_data;
    assign bus.s_r_resp   = bus.m_r_resp;
    assign bus.s_r_last   = bus.m_r_last;

    assign route_err = rst_n && ((bus.m_r_valid && !r_routable) || underflow);

endmodule
